// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// Imported by fetch_unit and its bench.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, boot/run/fault FSM,
// one-entry output register toward decode, handshake counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          MEM_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         hs;
  logic         load;

  // Misaligned or beyond the last word; limit kept 33 bits
  // so large memories cannot overflow the compare.
  function automatic logic addr_illegal(
    input logic [31:0] addr,
    input logic [31:0] msize
  );
    logic [32:0] lim;
    lim = {1'b0, msize} << 2;
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= lim);
  endfunction

  assign imem_addr = pc;
  assign hs        = out_valid && out_ready;
  assign load      = !out_valid || out_ready;

  // FSM, PC, output stage and counter updated together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      out_valid    <= 1'b0;
      out_instr    <= NOP_INSTR;
      out_pc       <= 32'h0;
      out_pc_plus4 <= 32'h4;
      fault        <= 1'b0;
      fault_pc     <= 32'h0;
      fetch_count  <= 32'h0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (hs) fetch_count <= fetch_count + 32'd1;
          if (redirect_valid) begin
            out_valid <= 1'b0;
            if (addr_illegal(redirect_pc, 32'(MEM_SIZE))) begin
              state    <= FAULT;
              fault    <= 1'b1;
              fault_pc <= redirect_pc;
            end else begin
              pc <= redirect_pc;
            end
          end else if (load) begin
            if (addr_illegal(pc, 32'(MEM_SIZE))) begin
              state     <= FAULT;
              fault     <= 1'b1;
              fault_pc  <= pc;
              out_valid <= 1'b0;
            end else begin
              out_valid    <= 1'b1;
              out_instr    <= imem_instr;
              out_pc       <= pc;
              out_pc_plus4 <= pc + 32'd4;
              pc           <= pc + 32'd4;
            end
          end
        end
        FAULT: state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a 256-word instance
// with stimulus and a 4-word instance running off the end.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic [31:0] a1, i1, rpc1, oi1, op1, op41, fpc1, cnt1;
  logic        rv1, ov1, rdy1, f1;
  logic [31:0] a2, i2, rpc2, oi2, op2, op42, fpc2, cnt2;
  logic        rv2, ov2, rdy2, f2;

  int checks = 0;
  int errors = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h0001_9E37) ^ 32'h0000_0013;
  endfunction

  assign i1 = memf(a1);
  assign i2 = memf(a2);

  fetch_unit #(.RESET_PC(32'h0), .MEM_SIZE(256)) u1 (
    .clk(clk), .rst(rst), .imem_addr(a1), .imem_instr(i1),
    .redirect_valid(rv1), .redirect_pc(rpc1),
    .out_valid(ov1), .out_ready(rdy1), .out_instr(oi1),
    .out_pc(op1), .out_pc_plus4(op41), .fault(f1),
    .fault_pc(fpc1), .fetch_count(cnt1)
  );

  fetch_unit #(.RESET_PC(32'h0), .MEM_SIZE(4)) u2 (
    .clk(clk), .rst(rst), .imem_addr(a2), .imem_instr(i2),
    .redirect_valid(rv2), .redirect_pc(rpc2),
    .out_valid(ov2), .out_ready(rdy2), .out_instr(oi2),
    .out_pc(op2), .out_pc_plus4(op42), .fault(f2),
    .fault_pc(fpc2), .fetch_count(cnt2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  // Handshakes on u1 pop the scoreboard.
  always @(negedge clk) begin
    if (!rst && ov1 && rdy1) begin
      if (q1.size() == 0) begin
        chk("sb1_empty", 32'(q1.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = q1.pop_front();
        chk("sb1_pc", op1, e);
        chk("sb1_instr", oi1, memf(e));
        chk("sb1_pc4", op41, e + 32'd4);
      end
    end
  end

  // Handshakes on u2 pop its scoreboard.
  always @(negedge clk) begin
    if (!rst && ov2 && rdy2) begin
      if (q2.size() == 0) begin
        chk("sb2_empty", 32'(q2.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = q2.pop_front();
        chk("sb2_pc", op2, e);
        chk("sb2_instr", oi2, memf(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rdy1 = 1'b1; rv1 = 1'b0; rpc1 = 32'h0;
    rdy2 = 1'b1; rv2 = 1'b0; rpc2 = 32'h0;
    cyc; cyc;
    chk("rst_valid", 32'(ov1), 32'd0);
    chk("rst_instr", oi1, NOP_INSTR);
    chk("rst_pc", op1, 32'h0);
    chk("rst_pc4", op41, 32'h4);
    chk("rst_fault", 32'(f1), 32'd0);
    chk("rst_fpc", fpc1, 32'h0);
    chk("rst_cnt", cnt1, 32'h0);
    chk("rst_addr", a1, 32'h0);

    q1.push_back(32'h0);  q1.push_back(32'h4);
    q1.push_back(32'h8);  q1.push_back(32'hC);
    q1.push_back(32'h10);
    q2.push_back(32'h0);  q2.push_back(32'h4);
    q2.push_back(32'h8);  q2.push_back(32'hC);
    rst = 1'b0;

    cyc;
    chk("boot_valid", 32'(ov1), 32'd0);
    chk("boot_addr", a1, 32'h0);
    cyc;
    chk("first_valid", 32'(ov1), 32'd1);
    chk("first_pc", op1, 32'h0);
    chk("first_cnt", cnt1, 32'h0);
    chk("u2_pc0", op2, 32'h0);
    cyc;
    chk("seq_pc4", op1, 32'h4);
    chk("seq_cnt1", cnt1, 32'd1);
    chk("u2_pc4", op2, 32'h4);
    cyc;
    chk("seq_pc8", op1, 32'h8);
    chk("seq_cnt2", cnt1, 32'd2);
    chk("seq_addr12", a1, 32'hC);
    chk("u2_pc8", op2, 32'h8);
    rdy1 = 1'b0;

    for (int k = 0; k < 3; k++) begin
      cyc;
      chk("bp_valid", 32'(ov1), 32'd1);
      chk("bp_pc", op1, 32'h8);
      chk("bp_instr", oi1, memf(32'h8));
      chk("bp_addr", a1, 32'hC);
      chk("bp_cnt", cnt1, 32'd2);
      if (k == 0) chk("u2_pc12", op2, 32'hC);
      if (k == 1) begin
        chk("u2_fault", 32'(f2), 32'd1);
        chk("u2_fpc", fpc2, 32'h10);
        chk("u2_valid", 32'(ov2), 32'd0);
        chk("u2_cnt", cnt2, 32'd4);
        chk("u2_addr", a2, 32'h10);
      end
    end
    rdy1 = 1'b1;

    cyc;
    chk("rel_pc12", op1, 32'hC);
    chk("rel_cnt3", cnt1, 32'd3);
    cyc;
    chk("rel_pc16", op1, 32'h10);
    chk("rel_cnt4", cnt1, 32'd4);
    rv1 = 1'b1; rpc1 = 32'h40;
    cyc;
    rv1 = 1'b0;
    chk("rd_flush", 32'(ov1), 32'd0);
    chk("rd_cnt", cnt1, 32'd5);
    chk("rd_addr", a1, 32'h40);
    q1.push_back(32'h40);
    q1.push_back(32'h44);
    cyc;
    chk("rd_valid", 32'(ov1), 32'd1);
    chk("rd_pc", op1, 32'h40);
    chk("rd_cnt_hold", cnt1, 32'd5);
    cyc;
    chk("rd_pc44", op1, 32'h44);
    chk("rd_cnt6", cnt1, 32'd6);
    rv1 = 1'b1; rpc1 = 32'h42;
    cyc;
    rv1 = 1'b0;
    chk("flt_fault", 32'(f1), 32'd1);
    chk("flt_fpc", fpc1, 32'h42);
    chk("flt_valid", 32'(ov1), 32'd0);
    chk("flt_cnt", cnt1, 32'd7);
    chk("flt_addr", a1, 32'h48);

    for (int k = 0; k < 4; k++) begin
      rv1  = 1'($urandom_range(0, 1));
      rdy1 = 1'($urandom_range(0, 1));
      rpc1 = 32'h80;
      cyc;
      chk("fh_fault", 32'(f1), 32'd1);
      chk("fh_valid", 32'(ov1), 32'd0);
      chk("fh_pc", op1, 32'h44);
      chk("fh_instr", oi1, memf(32'h44));
      chk("fh_fpc", fpc1, 32'h42);
      chk("fh_cnt", cnt1, 32'd7);
      chk("fh_addr", a1, 32'h48);
    end

    rv1 = 1'b0; rdy1 = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst2_fault", 32'(f1), 32'd0);
    cyc;
    q1.push_back(32'h0);
    q2.push_back(32'h0);
    rst = 1'b0;
    cyc;
    cyc;
    chk("r2_pc0", op1, 32'h0);
    cyc;
    chk("r2_pc4", op1, 32'h4);
    chk("r2_cnt1", cnt1, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ov1), 32'd0);
    chk("arst_addr", a1, 32'h0);
    chk("arst_cnt", cnt1, 32'd0);
    chk("arst_pc", op1, 32'h0);
    chk("arst_cnt2", cnt2, 32'd0);
    cyc;

    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
